seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter LEN, default 4, pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, match counter width in bits (legal 1..32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in  input  1  serial data bit.
REQ-006 SHALL have port in_valid  input  1  qualifies in; bit consumed only when 1.
REQ-007 SHALL have port overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-008 SHALL have port pattern  input  LEN  target sequence; pattern[LEN-1] is the first bit expected.
REQ-009 SHALL have port pat_load  input  1  captures pattern into the internal pattern register.
REQ-010 SHALL have port count_clr  input  1  synchronous clear of match_count.
REQ-011 SHALL have port out  output  1  registered Moore detect flag.
REQ-012 SHALL have port match_count  output  CNT_W  number of detected matches.

Function
REQ-013 SHALL hold an internal pattern register pat_r, a history shift register hist (LEN bits) and a fill counter fill (0..LEN).
REQ-014 On a clock edge with in_valid=1 and pat_load=0, SHALL shift hist <= {hist[LEN-2:0], in} and set fill <= min(fill+1, LEN).
REQ-015 A match SHALL occur on that edge when the updated fill equals LEN and the updated hist equals pat_r.
REQ-016 out SHALL be 1 for exactly the cycle following each match edge and 0 otherwise; out is a decoded state, never a combinational path from in.
REQ-017 Detection latency SHALL be one cycle: out rises on the edge that samples the final pattern bit.
REQ-018 With overlap=1 on a match edge, fill SHALL stay at LEN so following bits can complete a new match that reuses history.
REQ-019 With overlap=0 on a match edge, fill SHALL be cleared to 0, so a new match needs LEN fresh bits.
REQ-020 With in_valid=0, hist, fill and match_count SHALL hold and out SHALL be 0 on the next cycle.
REQ-021 pat_load=1 SHALL load pat_r <= pattern, clear fill to 0 and force out to 0 next cycle; a simultaneous in_valid bit SHALL be discarded.
REQ-022 overlap SHALL be sampled each edge; changing it mid-stream affects only the action taken on the next match edge.
REQ-023 No match SHALL be reported while fill < LEN, regardless of stale hist content.

Reset
REQ-024 While reset_n=0, SHALL asynchronously set hist=0, fill=0, out=0 and match_count=0.
REQ-025 While reset_n=0, pat_r SHALL be set to {LEN{1'b1}} with bit 1 cleared; for LEN=4 this is 4'b1101.
REQ-026 Reset asserted mid-sequence SHALL discard partial progress; detection restarts from fill=0 after release.

Configuration
REQ-027 Macro SEQ_DETECT_COUNT_EN SHALL control whether the match counter is compiled in.
REQ-028 With SEQ_DETECT_COUNT_EN defined, match_count SHALL increment by 1 on each match edge and saturate at all-ones.
REQ-029 With SEQ_DETECT_COUNT_EN defined, count_clr SHALL zero match_count; when count_clr coincides with a match, the result SHALL be 0.
REQ-030 With SEQ_DETECT_COUNT_EN undefined, match_count SHALL be constant 0, count_clr SHALL be ignored and no counter flops SHALL be inferred.

Verification
REQ-031 Reset, then LEN=4, overlap=1, stream 1,1,0,1,1,0,1 with in_valid=1 -> out pulses after bits 4 and 7; match_count=2.
REQ-032 Same stream with overlap=0 -> single out pulse after bit 4; match_count=1.
REQ-033 Load pattern 0110, stream 0,1,1,0 with in_valid deasserted for 3 cycles between bits 2 and 3 -> one out pulse after bit 4 only.
REQ-034 pat_load=1 with in_valid=1 on the cycle of the final bit of 1101 -> bit dropped, out stays 0, fill=0.
REQ-035 CNT_W=2, counter enabled, five overlap matches -> match_count saturates at 3; count_clr on a match edge -> 0.
REQ-036 reset_n pulsed low between bits 3 and 4 of 1101 -> no out pulse; the next full 1101 detects normally.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param -- serial pattern detector with programmable pattern,
// selectable overlapping / non-overlapping detection and an optional
// saturating match counter.
//
// Build option:
//    SEQ_DETECT_COUNT_EN  when defined, a CNT_W-bit saturating match counter
//                         drives match_count; when undefined match_count is
//                         tied to 0, count_clr is ignored and no counter
//                         flops exist.
//
// Operation summary:
//    - Each accepted bit (in_valid=1, pat_load=0) shifts into hist and bumps
//      the fill counter (saturating at LEN).
//    - A match is declared when the updated history is full and equals the
//      stored pattern; out is a registered flag that is high for exactly the
//      cycle after the match edge.
//    - On a match, overlap=1 keeps the history usable (fill stays at LEN),
//      overlap=0 empties it so LEN fresh bits are needed.
//    - pat_load captures a new pattern, empties the history and drops any
//      bit presented on the same edge.

module seq_detect_param #(
   parameter int LEN   = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in,
   input  logic             in_valid,
   input  logic             overlap,
   input  logic [LEN-1:0]   pattern,
   input  logic             pat_load,
   input  logic             count_clr,
   output logic             out,
   output logic [CNT_W-1:0] match_count
);

   // Fill counter must be able to represent 0..LEN inclusive.
   localparam int FILL_W = $clog2(LEN + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);

   // Power-up pattern: all ones with bit 1 cleared (1101 for LEN=4).
   localparam logic [LEN-1:0] PAT_RST = ~(LEN'(2));

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [LEN-1:0]    pat_q,  pat_d;
   logic [LEN-1:0]    hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              out_q,  out_d;

   // ---------------------------------------------------------------------
   // Derived values for the current edge
   // ---------------------------------------------------------------------
   logic              accept;      // a data bit is consumed on this edge
   logic [LEN-1:0]    hist_shift;  // history after shifting in the new bit
   logic [FILL_W-1:0] fill_inc;    // fill after counting the new bit
   logic              match;       // a full-pattern match completes here

   // An incoming bit is consumed only when valid and not pre-empted by a
   // pattern load on the same edge.
   assign accept = in_valid & ~pat_load;

   // New bit enters at the LSB; the oldest bit sits at the MSB so the
   // history lines up with pattern[LEN-1] as the first expected bit.
   assign hist_shift = {hist_q[LEN-2:0], in};

   // Fill saturates at LEN; beyond that the history simply slides.
   assign fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : (fill_q + FILL_W'(1));

   // Only a completely filled history may match, so stale bits left over
   // from before a clear or reload can never trigger a detection.
   assign match = accept && (fill_inc == FILL_FULL) && (hist_shift == pat_q);

   // Next-state logic for pattern, history, fill and the detect flag.
   always_comb begin
      pat_d  = pat_q;
      hist_d = hist_q;
      fill_d = fill_q;
      out_d  = 1'b0;

      if (pat_load) begin
         // Reload: new target, empty history, any bit on this edge dropped.
         pat_d  = pattern;
         fill_d = '0;
      end else if (in_valid) begin
         hist_d = hist_shift;
         if (match) begin
            out_d  = 1'b1;
            // Overlap decides whether the matched bits may seed the next match.
            fill_d = overlap ? FILL_FULL : '0;
         end else begin
            fill_d = fill_inc;
         end
      end
   end

   // Register update with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pat_q  <= PAT_RST;
         hist_q <= '0;
         fill_q <= '0;
         out_q  <= 1'b0;
      end else begin
         pat_q  <= pat_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         out_q  <= out_d;
      end
   end

   assign out = out_q;

   // ---------------------------------------------------------------------
   // Optional saturating match counter
   // ---------------------------------------------------------------------
`ifdef SEQ_DETECT_COUNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Clear wins over a coincident match; otherwise count up and saturate.
   always_comb begin
      cnt_d = cnt_q;
      if (count_clr) begin
         cnt_d = '0;
      end else if (match && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign match_count = cnt_q;
`else
   // Counter compiled out: output is a constant and the clear is ignored.
   logic unused_count_clr;
   assign unused_count_clr = count_clr;
   assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Testbench for seq_detect_param (LEN=4, CNT_W=2).
// A queue-based reference model tracks the bits seen since the history was
// last emptied; a match is "the last LEN bits of that queue equal the
// pattern". Directed scenarios come first, then a randomized stream.

module tb_seq_detect_param;

   localparam int LEN   = 4;
   localparam int CNT_W = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             in;
   logic             in_valid;
   logic             overlap;
   logic [LEN-1:0]   pattern;
   logic             pat_load;
   logic             count_clr;
   logic             out;
   logic [CNT_W-1:0] match_count;

   seq_detect_param #(.LEN(LEN), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in          (in),
      .in_valid    (in_valid),
      .overlap     (overlap),
      .pattern     (pattern),
      .pat_load    (pat_load),
      .count_clr   (count_clr),
      .out         (out),
      .match_count (match_count)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Reference model state
   // ------------------------------------------------------------------
   bit             m_bits[$];   // bits accepted since history was emptied
   logic [LEN-1:0] m_pat;
   logic           m_out;
   int             m_cnt;

   int total = 0;
   int bad   = 0;
   int pulses;                  // observed out pulses within a scenario

   function automatic logic [LEN-1:0] tail_value();
      logic [LEN-1:0] v = '0;
      foreach (m_bits[i]) v = {v[LEN-2:0], m_bits[i]};
      return v;
   endfunction

   function automatic logic [CNT_W-1:0] exp_count();
`ifdef SEQ_DETECT_COUNT_EN
      return CNT_W'(m_cnt);
`else
      return '0;
`endif
   endfunction

   task automatic check_outputs(input string tag);
      total++;
      assert (out === m_out) else begin
         bad++;
         $error("FAIL %s out: got %b want %b", tag, out, m_out);
      end
      total++;
      assert (match_count === exp_count()) else begin
         bad++;
         $error("FAIL %s match_count: got %0d want %0d", tag, match_count, exp_count());
      end
   endtask

   // One clock cycle: drive inputs, clock, advance the model, compare.
   task automatic step(input logic b, input logic v, input logic ov,
                       input logic pl, input logic [LEN-1:0] pat,
                       input logic cc, input string tag);
      bit matched;
      in = b; in_valid = v; overlap = ov; pat_load = pl; pattern = pat; count_clr = cc;
      @(posedge clk);
      #1;
      matched = 1'b0;
      if (pl) begin
         m_pat = pat;
         m_bits.delete();
      end else if (v) begin
         m_bits.push_back(b);
         if (m_bits.size() > LEN) void'(m_bits.pop_front());
         if (m_bits.size() == LEN && tail_value() == m_pat) begin
            matched = 1'b1;
            if (!ov) m_bits.delete();
         end
      end
      m_out = matched;
      if (cc) m_cnt = 0;
      else if (matched && m_cnt < CNT_MAX) m_cnt++;
      if (out === 1'b1) pulses++;
      check_outputs(tag);
      $display("step %-10s pl=%b v=%b in=%b ov=%b cc=%b -> out=%b cnt=%0d",
               tag, pl, v, b, ov, cc, out, match_count);
   endtask

   // Asynchronous reset pulse; checks the outputs clear before any edge.
   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      #2;
      m_bits.delete();
      m_pat = 4'b1101;
      m_out = 1'b0;
      m_cnt = 0;
      check_outputs(tag);
      @(posedge clk);
      #1;
      check_outputs(tag);
      reset_n = 1'b1;
      $display("reset %s -> out=%b cnt=%0d", tag, out, match_count);
   endtask

   task automatic check_pulses(input int want, input string tag);
      total++;
      assert (pulses === want) else begin
         bad++;
         $error("FAIL %s pulses: got %0d want %0d", tag, pulses, want);
      end
   endtask

   logic [6:0] stream7;
   bit         sb;

   initial begin
      reset_n = 1'b1; in = 1'b0; in_valid = 1'b0; overlap = 1'b0;
      pattern = '0; pat_load = 1'b0; count_clr = 1'b0;
      m_pat = 4'b1101; m_out = 1'b0; m_cnt = 0;
      #3;
      do_reset("init");

      // Overlapping detection of 1101 in 1101101: pulses after bits 4 and 7.
      stream7 = 7'b1101101;
      pulses = 0;
      for (int i = 6; i >= 0; i--) step(stream7[i], 1'b1, 1'b1, 1'b0, '0, 1'b0, "ovl");
      check_pulses(2, "ovl");

      // Same stream, non-overlapping: a single pulse after bit 4.
      do_reset("rst2");
      pulses = 0;
      for (int i = 6; i >= 0; i--) step(stream7[i], 1'b1, 1'b0, 1'b0, '0, 1'b0, "novl");
      check_pulses(1, "novl");

      // Pattern 0110 with a 3-cycle in_valid gap between bits 2 and 3.
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, 1'b0, "load0110");
      pulses = 0;
      step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, "gap");
      step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, "gap");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, "gap_idle");
      step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, "gap");
      step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, "gap");
      check_pulses(1, "gap");

      // pat_load on the final bit of 1101: bit dropped, history emptied.
      pulses = 0;
      step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1101, 1'b0, "ld1101");
      step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, "drop");
      step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, "drop");
      step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, "drop");
      step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1101, 1'b0, "drop_ld");
      step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, "drop_stale");
      check_pulses(0, "drop");

      // Five overlapping matches (counter saturates), then clear on a match.
      do_reset("rst3");
      pulses = 0;
      step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, "sat");
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, "sat");
         step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, "sat");
         step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, "sat");
      end
      check_pulses(5, "sat");
      step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, "clr");
      step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, "clr");
      step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, "clr_match");

      // Reset between bits 3 and 4 of 1101, then a full 1101 detects.
      pulses = 0;
      step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, "midrst");
      step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, "midrst");
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, "midrst");
      do_reset("midrst");
      step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, "midrst");
      check_pulses(0, "midrst");
      step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, "after");
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, "after");
      step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, "after");
      check_pulses(1, "after");

      // Randomized stream with occasional reloads, clears and resets.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset("rnd_rst");
         end else begin
            sb = 1'($urandom_range(0, 1));
            step(sb,
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 39) == 0),
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 29) == 0),
                 "rand");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
